// File: rtl/pcpi_cmd_initiator_if.sv
// Bundles the host command port, buffered response port and PCPI requester bus.
// The "master" modport is the initiator; "slave" is the host/responder side.
interface pcpi_cmd_initiator_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [31:0]           cmd_insn;
    logic [DATA_WIDTH-1:0] cmd_rs1;
    logic [DATA_WIDTH-1:0] cmd_rs2;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_wr;
    logic                  rsp_timeout;

    logic                  pcpi_valid;
    logic [31:0]           pcpi_insn;
    logic [DATA_WIDTH-1:0] pcpi_rs1;
    logic [DATA_WIDTH-1:0] pcpi_rs2;
    logic                  pcpi_wr;
    logic [DATA_WIDTH-1:0] pcpi_rd;
    logic                  pcpi_wait;
    logic                  pcpi_ready;

    modport master (
        input  cmd_valid, cmd_insn, cmd_rs1, cmd_rs2, rsp_ready,
               pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_wr, rsp_timeout,
               pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2
    );

    modport slave (
        output cmd_valid, cmd_insn, cmd_rs1, cmd_rs2, rsp_ready,
               pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_wr, rsp_timeout,
               pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2
    );
endinterface

// File: rtl/pcpi_cmd_initiator.sv
// Standalone PCPI requester: takes one host command, runs one PCPI transaction
// with the core's wait/timeout rules, and holds the result until the host takes it.
module pcpi_cmd_initiator #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                   clk,
    input  logic                   resetn,
    pcpi_cmd_initiator_if.master   bus,
    output logic                   busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    localparam logic [7:0] LAST_IDLE = 8'(TIMEOUT_CYCLES - 1);

    state_t                state_reg, state_next;
    logic [7:0]            count_reg, count_next;
    logic                  cmd_ready_reg, cmd_ready_next;
    logic                  pcpi_valid_reg, pcpi_valid_next;
    logic [31:0]           pcpi_insn_reg, pcpi_insn_next;
    logic [DATA_WIDTH-1:0] pcpi_rs1_reg, pcpi_rs1_next;
    logic [DATA_WIDTH-1:0] pcpi_rs2_reg, pcpi_rs2_next;
    logic                  rsp_valid_reg, rsp_valid_next;
    logic [DATA_WIDTH-1:0] rsp_data_reg, rsp_data_next;
    logic                  rsp_wr_reg, rsp_wr_next;
    logic                  rsp_timeout_reg, rsp_timeout_next;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg       <= IDLE;
            count_reg       <= '0;
            cmd_ready_reg   <= 1'b0;
            pcpi_valid_reg  <= 1'b0;
            pcpi_insn_reg   <= '0;
            pcpi_rs1_reg    <= '0;
            pcpi_rs2_reg    <= '0;
            rsp_valid_reg   <= 1'b0;
            rsp_data_reg    <= '0;
            rsp_wr_reg      <= 1'b0;
            rsp_timeout_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            count_reg       <= count_next;
            cmd_ready_reg   <= cmd_ready_next;
            pcpi_valid_reg  <= pcpi_valid_next;
            pcpi_insn_reg   <= pcpi_insn_next;
            pcpi_rs1_reg    <= pcpi_rs1_next;
            pcpi_rs2_reg    <= pcpi_rs2_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_data_reg    <= rsp_data_next;
            rsp_wr_reg      <= rsp_wr_next;
            rsp_timeout_reg <= rsp_timeout_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        count_next       = count_reg;
        cmd_ready_next   = cmd_ready_reg;
        pcpi_valid_next  = pcpi_valid_reg;
        pcpi_insn_next   = pcpi_insn_reg;
        pcpi_rs1_next    = pcpi_rs1_reg;
        pcpi_rs2_next    = pcpi_rs2_reg;
        rsp_valid_next   = rsp_valid_reg;
        rsp_data_next    = rsp_data_reg;
        rsp_wr_next      = rsp_wr_reg;
        rsp_timeout_next = rsp_timeout_reg;

        case (state_reg)
            IDLE: begin
                // cmd_ready is registered, so it first rises on the edge after reset release
                cmd_ready_next = 1'b1;
                if (bus.cmd_valid && cmd_ready_reg) begin
                    pcpi_insn_next  = bus.cmd_insn;
                    pcpi_rs1_next   = bus.cmd_rs1;
                    pcpi_rs2_next   = bus.cmd_rs2;
                    count_next      = '0;
                    pcpi_valid_next = 1'b1;
                    cmd_ready_next  = 1'b0;
                    state_next      = ISSUE;
                end
            end
            ISSUE: begin
                // ready beats wait, wait beats timeout; wait restarts the idle count
                if (bus.pcpi_ready) begin
                    rsp_data_next    = bus.pcpi_wr ? bus.pcpi_rd : '0;
                    rsp_wr_next      = bus.pcpi_wr;
                    rsp_timeout_next = 1'b0;
                    pcpi_valid_next  = 1'b0;
                    rsp_valid_next   = 1'b1;
                    state_next       = RESP;
                end else if (bus.pcpi_wait) begin
                    count_next = '0;
                end else if (count_reg == LAST_IDLE) begin
                    rsp_data_next    = '0;
                    rsp_wr_next      = 1'b0;
                    rsp_timeout_next = 1'b1;
                    pcpi_valid_next  = 1'b0;
                    rsp_valid_next   = 1'b1;
                    state_next       = RESP;
                end else begin
                    count_next = count_reg + 8'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    cmd_ready_next = 1'b1;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.cmd_ready   = cmd_ready_reg;
    assign bus.pcpi_valid  = pcpi_valid_reg;
    assign bus.pcpi_insn   = pcpi_insn_reg;
    assign bus.pcpi_rs1    = pcpi_rs1_reg;
    assign bus.pcpi_rs2    = pcpi_rs2_reg;
    assign bus.rsp_valid   = rsp_valid_reg;
    assign bus.rsp_data    = rsp_data_reg;
    assign bus.rsp_wr      = rsp_wr_reg;
    assign bus.rsp_timeout = rsp_timeout_reg;
    assign busy            = (state_reg != IDLE);
endmodule

// File: tb/tb_pcpi_cmd_initiator.sv
// Table-driven bench: each record scripts a PCPI responder and a host, results
// are checked through an expected-response queue, plus reset/spurious sequences.
module tb_pcpi_cmd_initiator;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic busy;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pcpi_cmd_initiator_if #(.DATA_WIDTH(32)) bus ();

    pcpi_cmd_initiator #(.TIMEOUT_CYCLES(16), .DATA_WIDTH(32)) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus),
        .busy  (busy)
    );

    typedef struct {
        string       name;
        logic [31:0] insn;
        logic [31:0] rs1;
        logic [31:0] rs2;
        int          idle_pre;   // silent pcpi_valid cycles before wait
        int          wait_cyc;   // cycles with pcpi_wait high
        int          idle_post;  // silent cycles after wait before ready
        bit          respond;    // 0: never assert pcpi_ready
        logic        wr;
        logic [31:0] rd;
        int          hold;       // rsp_valid cycles with rsp_ready low
        logic [31:0] exp_data;
        logic        exp_wr;
        logic        exp_to;
        int          exp_vcyc;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        wr;
        logic        to;
        int          vcyc;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pcpi_idle();
        bus.pcpi_ready = 1'b0;
        bus.pcpi_wait  = 1'b0;
        bus.pcpi_wr    = 1'b0;
        bus.pcpi_rd    = 32'h0;
    endtask

    task automatic wait_cmd_ready(input string name);
        int guard;
        guard = 0;
        while (bus.cmd_ready !== 1'b1 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        chk({name, " cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int   vcount, held, accept_cyc, lat;
        bit   seen, done;
        logic [31:0] d0;
        logic w0, t0;
        exp_t e;
        wait_cmd_ready(v.name);
        bus.cmd_valid = 1'b1;
        bus.cmd_insn  = v.insn;
        bus.cmd_rs1   = v.rs1;
        bus.cmd_rs2   = v.rs2;
        sb.push_back('{v.exp_data, v.exp_wr, v.exp_to, v.exp_vcyc});
        accept_cyc = cyc;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_insn  = $urandom;
        bus.cmd_rs1   = $urandom;
        bus.cmd_rs2   = $urandom;
        vcount = 0; held = 0; seen = 0; done = 0; d0 = '0; w0 = 0; t0 = 0;
        chk({v.name, " pcpi_valid rise"}, 32'(bus.pcpi_valid), 32'd1);
        for (int g = 0; g < 200 && !done; g++) begin
            pcpi_idle();
            if (bus.pcpi_valid) begin
                vcount++;
                if (bus.pcpi_insn !== v.insn || bus.pcpi_rs1 !== v.rs1 || bus.pcpi_rs2 !== v.rs2)
                    chk({v.name, " pcpi_insn"}, bus.pcpi_insn ^ bus.pcpi_rs1 ^ bus.pcpi_rs2,
                        v.insn ^ v.rs1 ^ v.rs2);
                chk({v.name, " cmd_ready busy"}, 32'(bus.cmd_ready), 32'd0);
                if (vcount <= v.idle_pre) begin
                end else if (vcount <= v.idle_pre + v.wait_cyc) begin
                    bus.pcpi_wait = 1'b1;
                end else if (v.respond && vcount > v.idle_pre + v.wait_cyc + v.idle_post) begin
                    bus.pcpi_ready = 1'b1;
                    bus.pcpi_wr    = v.wr;
                    bus.pcpi_rd    = v.rd;
                end
            end
            if (bus.rsp_valid) begin
                chk({v.name, " cmd_ready rsp"}, 32'(bus.cmd_ready), 32'd0);
                if (!seen) begin
                    seen = 1;
                    lat  = cyc - accept_cyc;
                    d0 = bus.rsp_data; w0 = bus.rsp_wr; t0 = bus.rsp_timeout;
                    chk({v.name, " latency"}, 32'(lat), 32'(v.exp_lat));
                end else begin
                    chk({v.name, " rsp stable"}, {bus.rsp_data[29:0], bus.rsp_wr, bus.rsp_timeout},
                        {d0[29:0], w0, t0});
                end
                if (held >= v.hold) begin
                    bus.rsp_ready = 1'b1;
                    done = 1;
                    if (sb.size() == 0) begin
                        chk({v.name, " sb underflow"}, 32'd0, 32'd1);
                    end else begin
                        e = sb.pop_front();
                        chk({v.name, " rsp_data"}, bus.rsp_data, e.data);
                        chk({v.name, " rsp_wr"}, 32'(bus.rsp_wr), 32'(e.wr));
                        chk({v.name, " rsp_timeout"}, 32'(bus.rsp_timeout), 32'(e.to));
                        chk({v.name, " pcpi_valid cycles"}, 32'(vcount), 32'(e.vcyc));
                    end
                end else begin
                    held++;
                end
            end
            @(negedge clk);
        end
        if (!done) chk({v.name, " response bound"}, 32'd0, 32'd1);
        bus.rsp_ready = 1'b0;
        pcpi_idle();
        chk({v.name, " rsp_valid drop"}, 32'(bus.rsp_valid), 32'd0);
        chk({v.name, " cmd_ready back"}, 32'(bus.cmd_ready), 32'd1);
        $display("txn %s: data=%h wr=%0b timeout=%0b pcpi_cycles=%0d", v.name, d0, w0, t0, vcount);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //        name        insn          rs1           rs2           pre wt post rsp  wr    rd            hold exp_data      wr    to    vcyc lat
        vecs[0] = '{"clmul_a",  32'h0820A1B3, 32'h0000000A, 32'h0000000E, 0,  0,  0, 1'b1, 1'b1, 32'h0000006C, 0, 32'h0000006C, 1'b1, 1'b0, 1,  2};
        vecs[1] = '{"clmul_b",  32'h0820A1B3, 32'h0000000A, 32'h0000000E, 0,  0,  0, 1'b1, 1'b1, 32'h0000006C, 5, 32'h0000006C, 1'b1, 1'b0, 1,  2};
        vecs[2] = '{"silent",   32'h02208233, 32'h00000011, 32'h00000022, 0,  0,  0, 1'b0, 1'b0, 32'h00000000, 0, 32'h00000000, 1'b0, 1'b1, 16, 17};
        vecs[3] = '{"longwait", 32'h0820A1B3, 32'h12345678, 32'h9ABCDEF0, 0, 40,  0, 1'b1, 1'b1, 32'h003A097A, 0, 32'h003A097A, 1'b1, 1'b0, 41, 42};
        vecs[4] = '{"prio_nowr",32'h02208233, 32'h00000001, 32'h00000002, 15, 0,  0, 1'b1, 1'b0, 32'hDEADBEEF, 1, 32'h00000000, 1'b0, 1'b0, 16, 17};
        vecs[5] = '{"wait_clr", 32'h0820A1B3, 32'hFFFFFFFF, 32'h00000003, 10, 3, 15, 1'b1, 1'b1, 32'h12345678, 2, 32'h12345678, 1'b1, 1'b0, 29, 30};
        vecs[6] = '{"wait_to",  32'h0820A1B3, 32'h00000005, 32'h00000007, 0,  2,  0, 1'b0, 1'b0, 32'h00000000, 0, 32'h00000000, 1'b0, 1'b1, 18, 19};
        vecs[7] = '{"late_rdy", 32'h0A0B0C0D, 32'h80000000, 32'h00000001, 14, 0,  0, 1'b1, 1'b1, 32'hCAFEF00D, 0, 32'hCAFEF00D, 1'b1, 1'b0, 15, 16};

        bus.cmd_valid = 1'b0;
        bus.cmd_insn  = '0;
        bus.cmd_rs1   = '0;
        bus.cmd_rs2   = '0;
        bus.rsp_ready = 1'b0;
        pcpi_idle();

        // Reset state while resetn is held low
        repeat (2) @(negedge clk);
        chk("reset cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("reset pcpi_valid", 32'(bus.pcpi_valid), 32'd0);
        chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset pcpi_insn", bus.pcpi_insn, 32'd0);
        chk("reset rsp_data", bus.rsp_data, 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        chk("post reset cmd_ready", 32'(bus.cmd_ready), 32'd1);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Spurious responder activity while idle must not create a response
        for (int i = 0; i < 3; i++) begin
            bus.pcpi_ready = 1'b1;
            bus.pcpi_wait  = 1'b1;
            bus.pcpi_wr    = 1'b1;
            bus.pcpi_rd    = 32'hBADC0DE0;
            @(negedge clk);
            chk("spurious rsp_valid", 32'(bus.rsp_valid), 32'd0);
            chk("spurious busy", 32'(busy), 32'd0);
        end
        pcpi_idle();
        $display("txn spurious: rsp_valid=%0b busy=%0b", bus.rsp_valid, busy);

        // Asynchronous reset during the 5th ISSUE cycle
        wait_cmd_ready("midreset");
        bus.cmd_valid = 1'b1;
        bus.cmd_insn  = 32'h0820A1B3;
        bus.cmd_rs1   = 32'hA;
        bus.cmd_rs2   = 32'hE;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("midreset pcpi_valid before", 32'(bus.pcpi_valid), 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("midreset pcpi_valid", 32'(bus.pcpi_valid), 32'd0);
        chk("midreset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("midreset busy", 32'(busy), 32'd0);
        chk("midreset pcpi_insn", bus.pcpi_insn, 32'd0);
        $display("txn midreset: pcpi_valid=%0b busy=%0b", bus.pcpi_valid, busy);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("midreset cmd_ready", 32'(bus.cmd_ready), 32'd1);
        run_vec(vecs[0]);

        chk("scoreboard empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
